// File: rtl/alu_iterative_if.sv
// Handshake bundle for alu_iterative.
//   Request side : in_valid, in_ready, operation, a, b
//   Response side: out_valid, out_ready, result, zero, illegal
// Valid/ready rule for both sides: a transfer happens on a rising clk edge where
// valid and ready are both high. The source holds its valid and payload steady
// until that edge. The sink may hold ready low for any number of cycles.
// Modports:
//   slave  - the ALU. It sinks requests and sources responses.
//   master - the producer/consumer environment driving the ALU.
interface alu_iterative_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      operation;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport slave (
    input  in_valid, operation, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

  modport master (
    output in_valid, operation, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU with an iterative logical right shift.
// AND/OR/ADD/SUB complete on the accept edge. SRL shifts one bit per clock.
// An illegal operation code completes on the accept edge with result=0, zero=1, illegal=1.
// Ports:
//   clk       - clock. All state updates on the rising edge.
//   rst_n     - asynchronous, active-low reset.
//   bus       - alu_iterative_if.slave. It carries the request and response handshakes.
//   dbg_state - current FSM state, for observation only.
// Operation codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0101 SRL.
// result, zero and illegal are registered.
// They keep their values from the time the op enters DONE until the next op completes.
module alu_iterative #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_iterative_if.slave     bus,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0101;

  logic [1:0]         state_q,   state_d;
  logic [XLEN-1:0]    result_q,  result_d;
  logic               zero_q,    zero_d;
  logic               illegal_q, illegal_d;
  logic [XLEN-1:0]    shreg_q,   shreg_d;
  logic [SHAMT_W-1:0] cnt_q,     cnt_d;

  logic [XLEN-1:0]    comb_res;
  logic               comb_ill;
  logic               go_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    shreg_next;

  assign shamt      = bus.b[SHAMT_W-1:0];
  assign shreg_next = shreg_q >> 1;

  // Single-cycle datapath, evaluated on the operands presented at the accept edge.
  always_comb begin
    comb_res = '0;
    comb_ill = 1'b0;
    go_shift = 1'b0;
    case (bus.operation)
      OP_AND: comb_res = bus.a & bus.b;
      OP_OR:  comb_res = bus.a | bus.b;
      OP_ADD: comb_res = bus.a + bus.b;
      OP_SUB: comb_res = bus.a - bus.b;
      OP_SRL: begin
        // A zero shift amount completes immediately with result = a.
        if (shamt == '0) comb_res = bus.a;
        else             go_shift = 1'b1;
      end
      default: comb_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (go_shift) begin
            shreg_d = bus.a;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            result_d  = comb_res;
            zero_d    = (comb_res == '0);
            illegal_d = comb_ill;
            state_d   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_next;
        cnt_d   = cnt_q - 1'b1;
        // The edge with cnt == 1 performs the final shift, so the value to publish is shreg_next.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d  = shreg_next;
          zero_d    = (shreg_next == '0);
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed corner cases plus randomized ops.
// Each op is checked against a plain-arithmetic reference model for latency,
// result/zero/illegal, hold-under-backpressure and return to idle.
module tb_alu_iterative;

  localparam int XLEN = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  alu_iterative_if #(.XLEN(XLEN)) bus ();

  alu_iterative #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Expected {illegal, zero, result} per accepted op.
  logic [XLEN+1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN+1:0] ref_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            ill;
    ill = 1'b0;
    r   = '0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0101: r = a >> b[4:0];
      default: ill = 1'b1;
    endcase
    return {ill, (r == '0), r};
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [XLEN-1:0] b);
    if (op == 4'b0101) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  function automatic logic [XLEN+1:0] observed();
    return {bus.illegal, bus.zero, bus.result};
  endfunction

  // ---------------- driver ----------------
  // Called at a point #1 after a rising edge with the DUT idle or busy.
  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int hold);
    logic [XLEN+1:0] got;
    int lat;
    int guard;
    int exp_lat;
    exp_lat = ref_latency(op, b);
    exp_q.push_back(ref_alu(op, a, b));
    bus.operation = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_timeout", 64'(guard < 100), 64'd1);
    @(posedge clk); #1;                        // accept edge
    // Scramble the inputs to prove the operands were captured.
    bus.in_valid  = 1'b0;
    bus.operation = 4'($urandom_range(0, 15));
    bus.a         = $urandom;
    bus.b         = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    got = observed();
    check("result", 64'(got), 64'(exp_q.pop_front()));
    check("in_ready_busy", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.operation = 4'($urandom_range(0, 15));
      bus.a         = $urandom;
      bus.b         = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_value", 64'(observed()), 64'(got));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", 64'(bus.out_valid), 64'd0);
    check("idle_ready", 64'(bus.in_ready), 64'd1);
    check("idle_keep", 64'(observed()), 64'(got));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ops [6];
    logic [3:0] op;
    logic       saw_valid;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0101; ops[5] = 4'b1111;
    n_checks = 0;
    n_errors = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operation = '0;
    bus.a         = '0;
    bus.b         = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outputs", 64'(observed()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1);
    run_op(4'b0110, 32'h5, 32'h5, 0);
    run_op(4'b0110, 32'h3, 32'h5, 2);
    run_op(4'b0101, 32'h8000_0000, 32'h0000_0024, 0);
    run_op(4'b0101, 32'h1234_5678, 32'hFFFF_FFE0, 0);
    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 10);
    run_op(4'b1111, 32'h1234_5678, 32'h1, 1);
    run_op(4'b0001, 32'h0F00_0000, 32'h0000_00F0, 0);
    run_op(4'b0101, 32'hFFFF_FFFF, 32'h1F, 0);

    // Reset in the middle of a long shift: the op must vanish.
    bus.operation = 4'b0101;
    bus.a         = 32'hFFFF_FFFF;
    bus.b         = 32'd31;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midshift_busy", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_outputs", 64'(observed()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_complete", 64'(saw_valid), 64'd0);

    // Randomized ops.
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 4'b1111) op = 4'($urandom_range(0, 15));
      run_op(op, $urandom, $urandom, $urandom_range(0, 3));
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
